// File: rtl/wb_stage_pipe_if.sv
// MEM->WB stage bus: upstream instruction fields in, register-file write port out.
interface wb_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    localparam int OFS_W = $clog2(DATA_W/8);

    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [2:0]        wb_sel;
    logic              reg_we_in;
    logic [REG_AW-1:0] rd_in;
    logic [2:0]        ld_funct3;
    logic [OFS_W-1:0]  ld_ofs;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] imme;
    logic [DATA_W-1:0] pc_add_4;
    logic [DATA_W-1:0] pc_add_imme;

    logic              wb_valid;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_misalign;

    modport master (
        output in_valid, stall, flush, wb_sel, reg_we_in, rd_in, ld_funct3, ld_ofs,
               mem_dout, alu_res, imme, pc_add_4, pc_add_imme,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_misalign
    );

    modport slave (
        input  in_valid, stall, flush, wb_sel, reg_we_in, rd_in, ld_funct3, ld_ofs,
               mem_dout, alu_res, imme, pc_add_4, pc_add_imme,
        output wb_valid, wb_we, wb_rd, wb_data, wb_misalign
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// MEM/WB register plus writeback select, load extraction, x0 suppression and misalign flag.
// Define WB_INSTRET_EN to add the 64-bit retired-instruction counter output instret.
module wb_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef WB_INSTRET_EN
    output logic [63:0] instret,
`endif
    wb_stage_pipe_if.slave bus
);
    localparam int OFS_W = $clog2(DATA_W/8);

    localparam logic [2:0] SEL_MEM   = 3'd1;
    localparam logic [2:0] SEL_ALU   = 3'd2;
    localparam logic [2:0] SEL_IMM   = 3'd3;
    localparam logic [2:0] SEL_PC4   = 3'd4;
    localparam logic [2:0] SEL_PCIMM = 3'd5;

    typedef struct packed {
        logic              vld;
        logic [2:0]        sel;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [2:0]        f3;
        logic [OFS_W-1:0]  ofs;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] pcimm;
    } pipe_t;

    pipe_t pipe_d, pipe_q;

    always_comb begin
        pipe_d = pipe_q;
        if (!bus.stall) begin
            pipe_d.vld   = bus.in_valid & ~bus.flush;
            pipe_d.sel   = bus.wb_sel;
            pipe_d.we    = bus.reg_we_in;
            pipe_d.rd    = bus.rd_in;
            pipe_d.f3    = bus.ld_funct3;
            pipe_d.ofs   = bus.ld_ofs;
            pipe_d.mem   = bus.mem_dout;
            pipe_d.alu   = bus.alu_res;
            pipe_d.imm   = bus.imme;
            pipe_d.pc4   = bus.pc_add_4;
            pipe_d.pcimm = bus.pc_add_imme;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    // Encodings with no native size at this DATA_W fall back to LW.
    logic [DATA_W-1:0] ld_sh, ld_val;
    assign ld_sh = pipe_q.mem >> {pipe_q.ofs, 3'b000};

    always_comb begin
        ld_val = DATA_W'($signed(ld_sh[31:0]));
        case (pipe_q.f3)
            3'b000:  ld_val = DATA_W'($signed(ld_sh[7:0]));
            3'b001:  ld_val = DATA_W'($signed(ld_sh[15:0]));
            3'b011:  if (DATA_W == 64) ld_val = ld_sh;
            3'b100:  ld_val = DATA_W'(ld_sh[7:0]);
            3'b101:  ld_val = DATA_W'(ld_sh[15:0]);
            3'b110:  if (DATA_W == 64) ld_val = DATA_W'(ld_sh[31:0]);
            default: ;
        endcase
    end

    logic is_half, is_dw, is_word, misaligned, misalign;
    assign is_half    = pipe_q.f3[1:0] == 2'b01;
    assign is_dw      = (DATA_W == 64) && (pipe_q.f3 == 3'b011);
    assign is_word    = pipe_q.f3[1] && !is_dw;
    assign misaligned = (is_half && pipe_q.ofs[0]) || (is_word && |pipe_q.ofs[1:0]) ||
                        (is_dw && |pipe_q.ofs);
    assign misalign   = pipe_q.vld && (pipe_q.sel == SEL_MEM) && pipe_q.we && misaligned;

    logic [DATA_W-1:0] sel_data;
    logic              sel_wr;

    always_comb begin
        sel_data = '0;
        sel_wr   = 1'b1;
        case (pipe_q.sel)
            SEL_MEM:   sel_data = ld_val;
            SEL_ALU:   sel_data = pipe_q.alu;
            SEL_IMM:   sel_data = pipe_q.imm;
            SEL_PC4:   sel_data = pipe_q.pc4;
            SEL_PCIMM: sel_data = pipe_q.pcimm;
            default:   sel_wr   = 1'b0;
        endcase
    end

    assign bus.wb_valid    = pipe_q.vld;
    assign bus.wb_data     = pipe_q.vld ? sel_data : '0;
    assign bus.wb_rd       = pipe_q.vld ? pipe_q.rd : '0;
    assign bus.wb_misalign = misalign;
    assign bus.wb_we       = pipe_q.vld & pipe_q.we & (|pipe_q.rd) & sel_wr & ~misalign;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_d, instret_q;
    assign instret_d = (!bus.stall && pipe_q.vld) ? instret_q + 64'd1 : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe (DATA_W=32): directed spec vectors plus randomized traffic
// against an arithmetic reference model of the writeback stage.
module tb_wb_stage_pipe;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    wb_stage_pipe_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef WB_INSTRET_EN
    logic [63:0] instret;
    wb_stage_pipe #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .instret(instret), .bus(bus));
`else
    wb_stage_pipe #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {valid, we, rd, data, misalign} and retired count
    logic [39:0]     exp_o;
    longint unsigned exp_ret;

    function automatic logic [39:0] model_out(input logic v, input logic [2:0] sel, input logic we,
                                              input logic [4:0] rd, input logic [2:0] f3,
                                              input logic [1:0] ofs, input logic [31:0] mem,
                                              input logic [31:0] alu, input logic [31:0] imm,
                                              input logic [31:0] pc4, input logic [31:0] pcimm);
        longint unsigned sh, full, raw;
        int              nbytes;
        logic            mis, wr;
        logic [31:0]     data;
        sh = longint'(mem) >> (ofs * 8);
        case (f3)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            default:    nbytes = 4;
        endcase
        full = 64'd1 << (8 * nbytes);
        raw  = sh % full;
        if (nbytes < 4 && f3 < 4 && raw >= full / 2) raw = raw + 64'h1_0000_0000 - full;
        mis = v && sel == 1 && we && (ofs % nbytes) != 0;
        case (sel)
            3'd1:    data = raw[31:0];
            3'd2:    data = alu;
            3'd3:    data = imm;
            3'd4:    data = pc4;
            3'd5:    data = pcimm;
            default: data = 32'd0;
        endcase
        if (!v) data = 32'd0;
        wr = v && we && rd != 0 && sel >= 1 && sel <= 5 && !mis;
        return {v, wr, (v ? rd : 5'd0), data, mis};
    endfunction

    task automatic drive(input logic v, input logic st, input logic fl, input logic [2:0] sel,
                         input logic we, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] ofs, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic [31:0] pcimm);
        bus.in_valid = v;   bus.stall = st;     bus.flush = fl;   bus.wb_sel = sel;
        bus.reg_we_in = we; bus.rd_in = rd;     bus.ld_funct3 = f3; bus.ld_ofs = ofs;
        bus.mem_dout = mem; bus.alu_res = alu;  bus.imme = imm;
        bus.pc_add_4 = pc4; bus.pc_add_imme = pcimm;
    endtask

    // Advance one clock edge and update the model from the stimulus present at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && !bus.stall) begin
            if (exp_o[39]) exp_ret++;
            exp_o = model_out(bus.in_valid & ~bus.flush, bus.wb_sel, bus.reg_we_in, bus.rd_in,
                              bus.ld_funct3, bus.ld_ofs, bus.mem_dout, bus.alu_res, bus.imme,
                              bus.pc_add_4, bus.pc_add_imme);
        end
        #1;
    endtask

    function automatic logic [39:0] act_o();
        return {bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data, bus.wb_misalign};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 0, 3'd2, 1, 5'd7, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'hABCD, 0, 0, 0);
        exp_o = '0; exp_ret = 0;
        #1;
        checks++;
        if (act_o() !== 40'd0) $display("FAIL reset_async: got %h expected 0", act_o());
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (act_o() !== 40'd0) $display("FAIL reset_hold: got %h expected 0", act_o());
        else passes++;
        @(negedge clk);
        drive(0, 0, 0, 3'd2, 1, 5'd7, 3'd0, 2'd0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (act_o() !== 40'd0) $display("FAIL idle_%0d: got %h expected 0", i, act_o());
            else passes++;
        end
`ifdef WB_INSTRET_EN
        checks++;
        if (instret !== 64'd0) $display("FAIL instret_reset: got %0d expected 0", instret);
        else passes++;
`endif
    endtask

    task automatic test_alu();
        @(negedge clk);
        drive(1, 0, 0, 3'd2, 1, 5'd5, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h1234, 32'h99, 32'h4, 32'h8);
        tick();
        checks++;
        if ({bus.wb_we, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd5, 32'h0000_1234})
            $display("FAIL alu_rd5: got we=%b rd=%0d data=%h expected we=1 rd=5 data=00001234",
                     bus.wb_we, bus.wb_rd, bus.wb_data);
        else passes++;
        @(negedge clk);
        bus.rd_in = 5'd0;
        tick();
        checks++;
        if (bus.wb_we !== 1'b0 || bus.wb_valid !== 1'b1)
            $display("FAIL alu_x0: got we=%b valid=%b expected we=0 valid=1", bus.wb_we, bus.wb_valid);
        else passes++;
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [1:0]  ofss [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 3'd1, 1, 5'd9, f3s[i], ofss[i], 32'h80FF_7F01, 32'h5, 32'h6, 32'h7, 32'h8);
            tick();
            checks++;
            if (bus.wb_data !== exps[i] || bus.wb_we !== 1'b1)
                $display("FAIL load_ext_f3_%0d_ofs%0d: got data=%h we=%b expected data=%h we=1",
                         f3s[i], ofss[i], bus.wb_data, bus.wb_we, exps[i]);
            else passes++;
        end
    endtask

    task automatic test_misalign();
        logic [2:0] f3s  [3] = '{3'd2, 3'd1, 3'd0};
        logic [1:0] ofss [3] = '{2'd2, 2'd1, 2'd3};
        logic       mis  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 3'd1, 1, 5'd3, f3s[i], ofss[i], 32'h1122_3344, 0, 0, 0, 0);
            tick();
            checks++;
            if (bus.wb_misalign !== mis[i] || bus.wb_we !== !mis[i] || bus.wb_valid !== 1'b1)
                $display("FAIL misalign_f3_%0d_ofs%0d: got mis=%b we=%b expected mis=%b we=%b",
                         f3s[i], ofss[i], bus.wb_misalign, bus.wb_we, mis[i], !mis[i]);
            else passes++;
        end
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        drive(1, 0, 0, 3'd4, 1, 5'd1, 3'd0, 2'd0, 0, 32'hAA, 32'hBB, 32'h104, 32'hCC);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 0, 3'd2, 1, 5'd6, 3'd0, 2'd0, 0, 32'hDEAD, 0, 0, 0);
            tick();
            checks++;
            if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} !== {1'b1, 1'b1, 5'd1, 32'h104})
                $display("FAIL stall_hold_%0d: got v=%b we=%b rd=%0d data=%h expected 1 1 1 00000104",
                         i, bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data);
            else passes++;
        end
        @(negedge clk);
        bus.flush = 1'b1;
        tick();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_data} !== {1'b1, 1'b1, 32'h104})
            $display("FAIL stall_beats_flush: got v=%b we=%b data=%h expected 1 1 00000104",
                     bus.wb_valid, bus.wb_we, bus.wb_data);
        else passes++;
        @(negedge clk);
        bus.stall = 1'b0;
        tick();
        checks++;
        if ({bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} !== {1'b0, 1'b0, 5'd0, 32'd0})
            $display("FAIL flush_kill: got v=%b we=%b rd=%0d data=%h expected all 0",
                     bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0, (i > 0) && $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, $urandom, $urandom);
            tick();
            checks++;
            if (act_o() !== exp_o) $display("FAIL random_%0d: got %h expected %h", i, act_o(), exp_o);
            else passes++;
        end
`ifdef WB_INSTRET_EN
        checks++;
        if (instret !== exp_ret) $display("FAIL instret_random: got %0d expected %0d", instret, exp_ret);
        else passes++;
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 3'd3, 1, 5'(i + 10), 3'd0, 2'd0, 0, 0, 32'(100 + i), 0, 0);
            tick();
            checks++;
            if ({bus.wb_we, bus.wb_rd, bus.wb_data} !== {1'b1, 5'(i + 10), 32'(100 + i)})
                $display("FAIL b2b_%0d: got we=%b rd=%0d data=%h expected we=1 rd=%0d data=%h",
                         i, bus.wb_we, bus.wb_rd, bus.wb_data, i + 10, 100 + i);
            else passes++;
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        drive(1, 0, 0, 3'd2, 1, 5'd4, 3'd0, 2'd0, 0, 32'h77, 0, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        exp_o = '0; exp_ret = 0;
        #1;
        checks++;
        if (act_o() !== 40'd0) $display("FAIL reset_midop: got %h expected 0", act_o());
        else passes++;
        @(negedge clk);
        drive(0, 0, 0, 3'd0, 0, 5'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret();
        test_reset_midop();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1, (i == 4 || i == 8), (i == 6), 3'd2, 1, 5'd2, 0, 0, 0, 32'(i), 0, 0, 0);
            tick();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (instret !== 64'd9) $display("FAIL instret_count: got %0d expected 9", instret);
        else passes++;
        @(negedge clk);
        bus.in_valid = 1'b1;
        tick();
        @(negedge clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret_q;
        tick();
        checks++;
        if (instret !== 64'd0) $display("FAIL instret_wrap: got %h expected 0", instret);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load_extend();
        test_misalign();
        test_stall_flush();
        test_back_to_back();
        test_random();
        test_reset_midop();
`ifdef WB_INSTRET_EN
        test_instret();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
